// File: rtl/hdmi_vmode_ctrl.sv
// Lock-qualification controller for measured HDMI video timing samples.
// Define VMODE_WATCHDOG_EN to add the missing-frame watchdog (LGTIMEOUT-bit counter).
module hdmi_vmode_ctrl #(
  parameter int unsigned LGTIMEOUT = 24,
  parameter int unsigned NLOCK     = 4,
  parameter int unsigned NUNLOCK   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_frame,
  input  logic [15:0] i_nlines,
  input  logic [15:0] i_sstart,
  input  logic [15:0] i_ssend,
  input  logic [15:0] i_vtotal,
  input  logic [15:0] i_npix,
  input  logic [15:0] i_htotal,
  output logic        o_locked,
  output logic        o_cfg_stb,
  output logic [15:0] o_nlines,
  output logic [15:0] o_sstart,
  output logic [15:0] o_ssend,
  output logic [15:0] o_vtotal,
  output logic [15:0] o_npix,
  output logic [15:0] o_htotal,
  output logic        o_int,
  output logic [1:0]  o_state
);

  localparam int unsigned MatchW = $clog2(NLOCK + 1);
  localparam int unsigned MissW  = $clog2(NUNLOCK + 1);
  localparam logic [MatchW-1:0] MatchMax = MatchW'(NLOCK);
  localparam logic [MissW-1:0]  MissMax  = MissW'(NUNLOCK);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSearch  = 2'd1,
    StQualify = 2'd2,
    StLocked  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [95:0]        cand_q, cand_d;
  logic [95:0]        mode_q, mode_d;
  logic [MatchW-1:0]  match_cnt_q, match_cnt_d;
  logic [MissW-1:0]   miss_cnt_q, miss_cnt_d;
  logic               locked_q, locked_d;
  logic               cfg_stb_q, cfg_stb_d;
  logic               int_q, int_d;

  logic [95:0]        sample;
  logic               sample_valid;
  logic               match_cand;
  logic               match_mode;
  logic [MatchW-1:0]  match_inc;
  logic [MissW-1:0]   miss_inc;
  logic               wd_expired;

  // Six fields packed in output order so candidate and mode compare as one word.
  assign sample = {i_nlines, i_sstart, i_ssend, i_vtotal, i_npix, i_htotal};

  assign sample_valid = (i_nlines != 16'd0) &&
                        (i_nlines < i_sstart) &&
                        (i_sstart <= i_ssend) &&
                        (i_ssend <= i_vtotal) &&
                        (i_npix != 16'd0) &&
                        (i_npix < i_htotal);

  assign match_cand = sample_valid && (sample == cand_q);
  assign match_mode = sample_valid && (sample == mode_q);

  assign match_inc = (match_cnt_q == MatchMax) ? match_cnt_q : match_cnt_q + MatchW'(1);
  assign miss_inc  = (miss_cnt_q == MissMax) ? miss_cnt_q : miss_cnt_q + MissW'(1);

`ifdef VMODE_WATCHDOG_EN
  localparam logic [LGTIMEOUT-1:0] WdMax = '1;

  logic [LGTIMEOUT-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (i_frame) begin
      wd_d = '0;
    end else if (wd_q != WdMax) begin
      wd_d = wd_q + LGTIMEOUT'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // A frame clears wd_d, so a frame on the expiry cycle wins automatically.
  assign wd_expired = (wd_d == WdMax);
`else
  logic unused_lgtimeout;
  assign unused_lgtimeout = ^LGTIMEOUT;
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    mode_d      = mode_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    cfg_stb_d   = 1'b0;
    int_d       = 1'b0;

    if (!i_enable) begin
      state_d     = StIdle;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      locked_d    = 1'b0;
      int_d       = locked_q;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSearch;
        end

        StSearch: begin
          if (i_frame && sample_valid) begin
            cand_d      = sample;
            match_cnt_d = MatchW'(1);
            state_d     = StQualify;
          end
        end

        StQualify: begin
          if (i_frame) begin
            if (match_cand) begin
              match_cnt_d = match_inc;
              if (match_inc == MatchMax) begin
                state_d    = StLocked;
                mode_d     = cand_q;
                miss_cnt_d = '0;
                locked_d   = 1'b1;
                cfg_stb_d  = 1'b1;
                int_d      = 1'b1;
              end
            end else if (sample_valid) begin
              cand_d      = sample;
              match_cnt_d = MatchW'(1);
            end else begin
              state_d     = StSearch;
              match_cnt_d = '0;
            end
          end else if (wd_expired) begin
            state_d     = StSearch;
            match_cnt_d = '0;
          end
        end

        StLocked: begin
          if (i_frame) begin
            if (match_mode) begin
              miss_cnt_d = '0;
            end else if (miss_inc == MissMax) begin
              // Mode registers are left holding the last published mode.
              state_d     = StSearch;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
              locked_d    = 1'b0;
              int_d       = 1'b1;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end else if (wd_expired) begin
            state_d     = StSearch;
            miss_cnt_d  = '0;
            match_cnt_d = '0;
            locked_d    = 1'b0;
            int_d       = 1'b1;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      cand_q      <= '0;
      mode_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      cfg_stb_q   <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      mode_q      <= mode_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      cfg_stb_q   <= cfg_stb_d;
      int_q       <= int_d;
    end
  end

  assign o_state   = state_q;
  assign o_locked  = locked_q;
  assign o_cfg_stb = cfg_stb_q;
  assign o_int     = int_q;
  assign o_nlines  = mode_q[95:80];
  assign o_sstart  = mode_q[79:64];
  assign o_ssend   = mode_q[63:48];
  assign o_vtotal  = mode_q[47:32];
  assign o_npix    = mode_q[31:16];
  assign o_htotal  = mode_q[15:0];

endmodule

// File: doc/hdmi_vmode_ctrl.md
# hdmi_vmode_ctrl

Lock-qualification controller that sits after the HDMI receive-side mode measurement logic. It takes one measured timing sample per frame, requires NLOCK identical valid samples before declaring lock, and then publishes a stable mode to the downstream framebuffer writer and timing generator. It drops lock after NUNLOCK consecutive bad frames or when software disables it, and it raises an interrupt on every lock-state change.

## Interface
- LGTIMEOUT, 24: watchdog counter width; expiry occurs at 2^LGTIMEOUT-1 cycles with no frame.
- NLOCK, 4: consecutive matching valid frames required to lock (≥2).
- NUNLOCK, 2: consecutive mismatching frames required to unlock (≥1).

- i_clk  in  1  system clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  software enable; low forces IDLE.
- i_frame  in  1  one-cycle strobe; i_nlines..i_htotal are valid in this cycle.
- i_nlines, i_sstart, i_ssend, i_vtotal  in  16 each  measured vertical active lines, sync start, sync end, total lines.
- i_npix, i_htotal  in  16 each  measured horizontal active pixels and total pixels.
- o_locked  out  1  stable mode is published.
- o_cfg_stb  out  1  one-cycle pulse when the o_* mode registers update.
- o_nlines, o_sstart, o_ssend, o_vtotal, o_npix, o_htotal  out  16 each  published mode.
- o_int  out  1  one-cycle pulse on any change of o_locked.
- o_state  out  2  0=IDLE, 1=SEARCH, 2=QUALIFY, 3=LOCKED.

## Operation
- A sample is valid only if all of the following hold: nlines≠0, nlines<sstart, sstart≤ssend, ssend≤vtotal, npix≠0, npix<htotal. All comparisons are unsigned 16-bit.
- A match means all six fields are equal to the reference set. In QUALIFY the reference is the candidate register; in LOCKED it is the o_* registers. An invalid sample never matches.
- IDLE: enter SEARCH on the next cycle when i_enable=1.
- SEARCH, on i_frame:
  - Valid sample: capture it as the candidate, set the match count to 1, go to QUALIFY.
  - Invalid sample: stay in SEARCH.
- QUALIFY, on i_frame:
  - Match: increment the match count. When the count reaches NLOCK, go to LOCKED, copy the candidate into the o_* registers, and pulse o_cfg_stb and o_int.
  - Valid mismatch: replace the candidate, set the count to 1, stay in QUALIFY.
  - Invalid sample: go to SEARCH.
- LOCKED, on i_frame:
  - Match: clear the miss count.
  - Mismatch (valid or invalid): increment the miss count. When it reaches NUNLOCK, go to SEARCH, drop o_locked, and pulse o_int.
  - The o_* mode registers keep their last value after unlock.
- i_enable=0 in any state: go to IDLE next cycle and clear the counts. Pulse o_int if the block was LOCKED.
- Priority, highest first: i_reset, i_enable low, i_frame, watchdog expiry.
- Counters saturate and never wrap.

## Timing
- Reset values: o_locked=0, o_cfg_stb=0, o_int=0, o_state=0, all o_* mode registers 0, all counts 0.
- Every output is a register.
- o_locked, o_state, o_cfg_stb, o_int and the o_* mode registers update in the cycle after the deciding i_frame (one-cycle latency).
- o_cfg_stb is coincident with the first cycle the new o_* values are visible.
- i_frame may arrive on back-to-back cycles; each strobe is processed independently.
- Reset asserted mid-qualification or while locked: state, counts and outputs return to their reset values on the next edge. No o_int pulse is generated.

## Configuration
- VMODE_WATCHDOG_EN defined:
  - A LGTIMEOUT-bit counter clears on i_frame and otherwise increments, saturating.
  - If it reaches 2^LGTIMEOUT-1 while in QUALIFY or LOCKED, go to SEARCH. Pulse o_int if the block was LOCKED.
  - If i_frame arrives in the same cycle as expiry, the frame is processed and the watchdog does not fire.
- VMODE_WATCHDOG_EN undefined: no counter exists. Lock is lost only through mismatches, i_enable or reset.

## Test plan
- Reset with i_enable=1 -> every output is 0 for the reset cycle; o_state=1 one cycle after reset is released.
- Four 1080p frames (1080/1084/1089/1125, 1920/2200) -> o_locked rises 1 cycle after the 4th frame; o_cfg_stb and o_int each pulse once; o_* equal the 1080p values.
- Locked at 1080p: one 720p frame, then 1080p -> stays locked, no o_int. Two consecutive 720p frames -> unlock after the 2nd, one o_int pulse, o_nlines still 1080.
- QUALIFY with three 1080p matches, then 720p (720/725/730/750, 1280/1650) -> o_state stays 2; lock occurs only after the 4th 720p frame, and o_nlines=720.
- SEARCH with an invalid sample (sstart=1000 < nlines=1080) -> o_state stays 1. i_enable dropped while LOCKED -> o_state=0 next cycle, o_int pulses.
- VMODE_WATCHDOG_EN, LGTIMEOUT=8: locked, then no frames for 255 cycles -> o_state=1 and o_int pulses. A frame that arrives exactly on the expiry cycle -> lock is retained.
